// File: rtl/pwm_ramp_ctrl_if.sv
// Control-side view of one PWM generator: enable, duty-load strobe/value and
// single-LSB step pulses. The sequencer drives (master); the generator listens.
interface pwm_ramp_ctrl_if #(
  parameter int DUTY_W = 3
);
  logic              pwm_en;
  logic              pwm_rst;
  logic [DUTY_W-1:0] pwm_duty;
  logic              pwm_duty_inc;
  logic              pwm_duty_dec;

  // No backpressure: the generator must act on every pulse/strobe in the cycle it is high.
  modport master (
    output pwm_en,
    output pwm_rst,
    output pwm_duty,
    output pwm_duty_inc,
    output pwm_duty_dec
  );

  modport slave (
    input pwm_en,
    input pwm_rst,
    input pwm_duty,
    input pwm_duty_inc,
    input pwm_duty_dec
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Ramp sequencer for a PWM generator: loads an initial duty, steps it one LSB
// per STEP_DIV cycles toward a target, ramps down on stop, drops out on fault.
module pwm_ramp_ctrl #(
  parameter int DUTY_W   = 3,
  parameter int DUTY_MAX = 7,
  parameter int STEP_DIV = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              fault_i,
  input  logic              fault_clr_i,
  input  logic [DUTY_W-1:0] target_i,
  input  logic [DUTY_W-1:0] init_duty_i,
  pwm_ramp_ctrl_if.master   pwm,
  output logic [DUTY_W-1:0] cur_duty_o,
  output logic              busy_o,
  output logic              at_target_o,
  output logic              fault_latched_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RAMP  = 3'd2,
    S_HOLD  = 3'd3,
    S_DOWN  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam logic [DUTY_W-1:0] DMAX = DUTY_W'(DUTY_MAX);
  localparam logic [15:0]       TERM = 16'(STEP_DIV - 1);

  state_t            state_q;
  logic [15:0]       timer_q;
  logic [DUTY_W-1:0] cur_q;
  logic [DUTY_W-1:0] duty_q;
  logic              en_q, rst_q, inc_q, dec_q;
  logic              busy_q, at_q, flt_q;

  logic [DUTY_W-1:0] tgt_c, init_c;
  logic              tc;

  assign tgt_c  = (target_i > DMAX) ? DMAX : target_i;
  assign init_c = (init_duty_i > DMAX) ? DMAX : init_duty_i;
  assign tc     = (timer_q == TERM);

  // The timer is zeroed on the edge that enters LOAD/RAMP/DOWN, so the first
  // step lands exactly STEP_DIV cycles after that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      cur_q   <= '0;
      duty_q  <= '0;
      en_q    <= 1'b0;
      rst_q   <= 1'b0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      busy_q  <= 1'b0;
      at_q    <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      rst_q <= 1'b0;
      if (fault_i) begin
        state_q <= S_FAULT;
        timer_q <= '0;
        cur_q   <= '0;
        duty_q  <= '0;
        en_q    <= 1'b0;
        busy_q  <= 1'b0;
        at_q    <= 1'b0;
        flt_q   <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              state_q <= S_LOAD;
              timer_q <= '0;
              en_q    <= 1'b1;
              rst_q   <= 1'b1;
              duty_q  <= init_c;
              cur_q   <= init_c;
              busy_q  <= 1'b1;
            end
          end
          S_LOAD: begin
            if (stop_i) begin
              state_q <= S_DOWN;
              timer_q <= '0;
            end else begin
              state_q <= S_RAMP;
              timer_q <= timer_q + 16'd1;
            end
          end
          S_RAMP: begin
            if (stop_i) begin
              state_q <= S_DOWN;
              timer_q <= '0;
            end else if (tc) begin
              timer_q <= '0;
              if (cur_q < tgt_c) begin
                inc_q <= 1'b1;
                cur_q <= cur_q + 1'b1;
              end else if (cur_q > tgt_c) begin
                dec_q <= 1'b1;
                cur_q <= cur_q - 1'b1;
              end else begin
                state_q <= S_HOLD;
                at_q    <= 1'b1;
              end
            end else begin
              timer_q <= timer_q + 16'd1;
            end
          end
          S_HOLD: begin
            timer_q <= '0;
            if (stop_i) begin
              state_q <= S_DOWN;
              at_q    <= 1'b0;
            end else if (tgt_c != cur_q) begin
              state_q <= S_RAMP;
              at_q    <= 1'b0;
            end
          end
          S_DOWN: begin
            if (tc) begin
              timer_q <= '0;
              if (cur_q == '0) begin
                state_q <= S_IDLE;
                en_q    <= 1'b0;
                busy_q  <= 1'b0;
              end else begin
                dec_q <= 1'b1;
                cur_q <= cur_q - 1'b1;
              end
            end else begin
              timer_q <= timer_q + 16'd1;
            end
          end
          S_FAULT: begin
            if (fault_clr_i) begin
              state_q <= S_IDLE;
              flt_q   <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            at_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pwm.pwm_en       = en_q;
  assign pwm.pwm_rst      = rst_q;
  assign pwm.pwm_duty     = duty_q;
  assign pwm.pwm_duty_inc = inc_q;
  assign pwm.pwm_duty_dec = dec_q;
  assign cur_duty_o       = cur_q;
  assign busy_o           = busy_q;
  assign at_target_o      = at_q;
  assign fault_latched_o  = flt_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with DUTY_MAX=6, STEP_DIV=4: ramp up,
// retarget, stop ramp-down, clamping, fault latch/clear, async reset.
module tb_pwm_ramp_ctrl;
  localparam int DUTY_W   = 3;
  localparam int DUTY_MAX = 6;
  localparam int STEP     = 4;

  localparam int ST_IDLE  = 0;
  localparam int ST_LOAD  = 1;
  localparam int ST_RAMP  = 2;
  localparam int ST_HOLD  = 3;
  localparam int ST_DOWN  = 4;
  localparam int ST_FAULT = 5;

  logic              clk;
  logic              rst_n;
  logic              start_i, stop_i, fault_i, fault_clr_i;
  logic [DUTY_W-1:0] target_i, init_duty_i;
  logic [DUTY_W-1:0] cur_duty_o;
  logic              busy_o, at_target_o, fault_latched_o;
  logic [2:0]        state_o;

  int n_checks = 0;
  int n_errors = 0;
  int inv_err  = 0;

  pwm_ramp_ctrl_if #(.DUTY_W(DUTY_W)) pif ();

  pwm_ramp_ctrl #(
    .DUTY_W  (DUTY_W),
    .DUTY_MAX(DUTY_MAX),
    .STEP_DIV(STEP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .fault_i        (fault_i),
    .fault_clr_i    (fault_clr_i),
    .target_i       (target_i),
    .init_duty_i    (init_duty_i),
    .pwm            (pif),
    .cur_duty_o     (cur_duty_o),
    .busy_o         (busy_o),
    .at_target_o    (at_target_o),
    .fault_latched_o(fault_latched_o),
    .state_o        (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // STEP-1 quiet cycles, then one step pulse of the given kind
  task automatic expect_interval(input string tag, input logic inc, input logic dec,
                                 input int cur);
    for (int i = 0; i < STEP - 1; i++) begin
      step();
      chk({tag, "_quiet"}, {30'd0, pif.pwm_duty_inc, pif.pwm_duty_dec}, 0);
    end
    step();
    chk({tag, "_inc"}, pif.pwm_duty_inc, inc);
    chk({tag, "_dec"}, pif.pwm_duty_dec, dec);
    chk({tag, "_cur"}, cur_duty_o, cur);
  endtask

  // After the last dec to 0, one more interval ends in IDLE with no pulse
  task automatic expect_idle_after_down(input string tag);
    for (int i = 0; i < STEP - 1; i++) begin
      step();
      chk({tag, "_still_en"}, pif.pwm_en, 1);
    end
    step();
    chk({tag, "_state"}, state_o, ST_IDLE);
    chk({tag, "_en"}, pif.pwm_en, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_dec"}, pif.pwm_duty_dec, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pif.pwm_duty_inc && pif.pwm_duty_dec) inv_err++;
      if ((pif.pwm_duty_inc || pif.pwm_duty_dec) && (!pif.pwm_en || pif.pwm_rst)) inv_err++;
      if (cur_duty_o > DUTY_W'(DUTY_MAX)) inv_err++;
    end
  end

  initial begin
    rst_n = 1'b0; start_i = 0; stop_i = 0; fault_i = 0; fault_clr_i = 0;
    target_i = '0; init_duty_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {pif.pwm_en, pif.pwm_rst, pif.pwm_duty, pif.pwm_duty_inc,
                        pif.pwm_duty_dec, cur_duty_o, busy_o, at_target_o,
                        fault_latched_o, state_o}, 0);
    rst_n = 1'b1;
    step();
    chk("idle_after_rst", state_o, ST_IDLE);

    // basic ramp-up 1 -> 5
    init_duty_i = 3'd1; target_i = 3'd5; start_i = 1;
    step();
    start_i = 0;
    chk("load_state", state_o, ST_LOAD);
    chk("load_en", pif.pwm_en, 1);
    chk("load_rst", pif.pwm_rst, 1);
    chk("load_duty", pif.pwm_duty, 1);
    chk("load_cur", cur_duty_o, 1);
    chk("load_busy", busy_o, 1);
    for (int p = 2; p <= 5; p++) expect_interval("up", 1'b1, 1'b0, p);
    chk("up_rst_low", pif.pwm_rst, 0);
    for (int i = 0; i < STEP - 1; i++) begin
      step();
      chk("up_not_at", at_target_o, 0);
    end
    step();
    chk("up_at_target", at_target_o, 1);
    chk("up_hold", state_o, ST_HOLD);

    // retarget 5 -> 2 while holding
    target_i = 3'd2;
    step();
    chk("rt_ramp", state_o, ST_RAMP);
    chk("rt_at_low", at_target_o, 0);
    for (int p = 4; p >= 2; p--) expect_interval("rt", 1'b0, 1'b1, p);
    for (int i = 0; i < STEP - 1; i++) step();
    step();
    chk("rt_hold", state_o, ST_HOLD);
    chk("rt_at", at_target_o, 1);

    // stop from HOLD at 2
    stop_i = 1;
    step();
    stop_i = 0;
    chk("sh_down", state_o, ST_DOWN);
    chk("sh_busy", busy_o, 1);
    chk("sh_at", at_target_o, 0);
    expect_interval("sh", 1'b0, 1'b1, 1);
    expect_interval("sh", 1'b0, 1'b1, 0);
    expect_idle_after_down("sh_end");

    // stop mid ramp-up at 3, start ignored in DOWN
    init_duty_i = 3'd1; target_i = 3'd5; start_i = 1;
    step();
    start_i = 0;
    expect_interval("sm_up", 1'b1, 1'b0, 2);
    expect_interval("sm_up", 1'b1, 1'b0, 3);
    stop_i = 1;
    step();
    stop_i = 0;
    chk("sm_down", state_o, ST_DOWN);
    start_i = 1;
    step();
    start_i = 0;
    chk("sm_start_ign", state_o, ST_DOWN);
    step();
    step();
    step();
    chk("sm_dec2", pif.pwm_duty_dec, 1);
    chk("sm_cur2", cur_duty_o, 2);
    expect_interval("sm", 1'b0, 1'b1, 1);
    expect_interval("sm", 1'b0, 1'b1, 0);
    expect_idle_after_down("sm_end");

    // clamping: 7 -> DUTY_MAX 6
    init_duty_i = 3'd7; target_i = 3'd7; start_i = 1;
    step();
    start_i = 0;
    chk("cl_duty", pif.pwm_duty, 6);
    chk("cl_cur", cur_duty_o, 6);
    for (int i = 0; i < STEP - 1; i++) begin
      step();
      chk("cl_quiet", {30'd0, pif.pwm_duty_inc, pif.pwm_duty_dec}, 0);
    end
    step();
    chk("cl_hold", state_o, ST_HOLD);
    chk("cl_at", at_target_o, 1);
    chk("cl_nopulse", {30'd0, pif.pwm_duty_inc, pif.pwm_duty_dec}, 0);

    // fault at cur_duty 4
    target_i = 3'd4;
    step();
    chk("ft_ramp", state_o, ST_RAMP);
    expect_interval("ft", 1'b0, 1'b1, 5);
    expect_interval("ft", 1'b0, 1'b1, 4);
    fault_i = 1;
    step();
    chk("ft_state", state_o, ST_FAULT);
    chk("ft_en", pif.pwm_en, 0);
    chk("ft_latched", fault_latched_o, 1);
    chk("ft_cur", cur_duty_o, 0);
    chk("ft_busy", busy_o, 0);
    fault_clr_i = 1;
    step();
    chk("ft_clr_blocked", state_o, ST_FAULT);
    chk("ft_still_latched", fault_latched_o, 1);
    fault_i = 0;
    step();
    fault_clr_i = 0;
    chk("ft_cleared", state_o, ST_IDLE);
    chk("ft_unlatched", fault_latched_o, 0);

    // async reset mid-ramp, then restart with start+stop together
    init_duty_i = 3'd2; target_i = 3'd5; start_i = 1;
    step();
    start_i = 0;
    chk("ar_load_cur", cur_duty_o, 2);
    expect_interval("ar_up", 1'b1, 1'b0, 3);
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_outputs", {pif.pwm_en, pif.pwm_rst, pif.pwm_duty, pif.pwm_duty_inc,
                       pif.pwm_duty_dec, cur_duty_o, busy_o, at_target_o,
                       fault_latched_o, state_o}, 0);
    step();
    step();
    rst_n = 1'b1;
    start_i = 1; stop_i = 1;
    step();
    start_i = 0; stop_i = 0;
    chk("ar_restart_state", state_o, ST_LOAD);
    chk("ar_restart_duty", pif.pwm_duty, 2);
    chk("ar_restart_cur", cur_duty_o, 2);
    expect_interval("ar_re", 1'b1, 1'b0, 3);

    chk("invariants", inv_err, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Sequencer for one 3-bit PWM generator: enables it, preloads the initial duty, and ramps duty toward a target by one LSB every STEP_DIV cycles.
- On stop, ramps duty back down before disabling the generator. On fault, disables immediately.
- Sits between the control/register logic (start, stop, target) and the PWM generator's en/rst/duty/duty_inc/duty_dec inputs.

Parameters:
- DUTY_W, 3, width of duty values; must match the PWM generator.
- DUTY_MAX, 7, largest legal duty; target and init_duty are clamped to this value.
- STEP_DIV, 16, clock cycles between ramp steps; legal range 2..65535.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin operation; honoured only in IDLE.
- stop  in  1  one-cycle request to ramp down and disable; honoured in LOAD, RAMP and HOLD.
- fault  in  1  level input; forces shutdown.
- fault_clr  in  1  clears a latched fault; honoured only in FAULT.
- target  in  DUTY_W  requested steady-state duty; sampled every cycle.
- init_duty  in  DUTY_W  duty loaded into the generator at start.
- pwm_en  out  1  generator enable.
- pwm_rst  out  1  generator duty-load strobe.
- pwm_duty  out  DUTY_W  generator load value.
- pwm_duty_inc  out  1  one-cycle increment pulse to the generator.
- pwm_duty_dec  out  1  one-cycle decrement pulse to the generator.
- cur_duty  out  DUTY_W  shadow copy of the generator's duty.
- busy  out  1  high in any state except IDLE and FAULT.
- at_target  out  1  high only in HOLD.
- fault_latched  out  1  high in FAULT.

Behaviour:
- All outputs are registered.
- Reset (rst_n low) forces state IDLE and drives every output to 0. Reset asserted in any state, including mid-ramp, aborts the sequence with no ramp-down.
- Definition: tgt_c = min(target, DUTY_MAX); init_c = min(init_duty, DUTY_MAX).
- IDLE: pwm_en=0. On start, go to LOAD.
- LOAD (exactly 1 cycle): pwm_en=1, pwm_rst=1, pwm_duty=init_c, cur_duty<=init_c, step timer cleared. Then go to RAMP.
- RAMP: pwm_en=1, pwm_rst=0. The step timer counts 0..STEP_DIV-1. At terminal count:
  - cur_duty < tgt_c: pulse pwm_duty_inc for 1 cycle, cur_duty+1.
  - cur_duty > tgt_c: pulse pwm_duty_dec for 1 cycle, cur_duty-1.
  - cur_duty == tgt_c: go to HOLD with no pulse.
  - The timer wraps to 0 after each terminal count.
  - The first step pulse appears STEP_DIV cycles after LOAD.
- HOLD: at_target=1; timer held at 0. If tgt_c != cur_duty, return to RAMP; the next step occurs after a full STEP_DIV interval.
- DOWN (entered on stop): ramps toward 0 using the same step timing, ignoring target.
  - When cur_duty==0 at a terminal count, go to IDLE with pwm_en=0 on that transition.
  - start is ignored in DOWN.
- FAULT: entered from any state on fault=1 (registered, 1-cycle latency).
  - pwm_en=0, pulses=0, cur_duty<=0, fault_latched=1.
  - Leave to IDLE only when fault_clr=1 and fault=0 in the same cycle.
- Priority within a cycle: fault > stop > start/target change. stop and start together in IDLE: stop is ignored and start proceeds.
- Invariants:
  - pwm_duty_inc and pwm_duty_dec are never high together.
  - Neither pulse is asserted while pwm_en=0 or pwm_rst=1.
  - pwm_duty_inc never drives cur_duty above DUTY_MAX; pwm_duty_dec never drives it below 0.
  - cur_duty always equals the generator's internal duty.

Test Plan:
- Basic ramp-up: STEP_DIV=4, init_duty=1, target=5, start pulse -> LOAD 1 cycle, then inc pulses every 4 cycles, cur_duty 2,3,4,5, at_target high 4 cycles after the final pulse.
- Retarget while holding: in HOLD at 5, target=2 -> three dec pulses 4 cycles apart, cur_duty 4,3,2, HOLD re-entered.
- Clamping: target=7, init_duty=7, DUTY_MAX=6 -> pwm_duty=6 at LOAD, no pulses, HOLD after 4 cycles.
- Stop mid-ramp: stop at cur_duty=3 during ramp-up -> dec pulses to 0, then pwm_en=0 and busy=0; a start during the ramp-down is ignored.
- Fault: fault high at cur_duty=4 -> next cycle pwm_en=0, fault_latched=1; fault_clr while fault=1 has no effect; fault_clr with fault=0 -> IDLE.
- Async reset mid-ramp: rst_n low between edges -> all outputs 0 immediately; after release, start restarts cleanly from init_duty.
